// File: rtl/fft_pkg.sv
// Shared definitions for the 64-point R2SDF FFT pipeline.
// Contents: transform size constants, twiddle ROM address width, the stage
// sequencer state type and half_of(), which maps a stage index to its delay depth.
package fft_pkg;

   localparam int unsigned FFT_N  = 64;
   localparam int unsigned LOG2_N = 6;
   localparam int unsigned TW_AW  = 5;

   // Stage sequencer states
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } sdf_state_e;

   // Delay-line depth (samples per half frame) of stage s
   function automatic int unsigned half_of(input int unsigned stage);
      return (FFT_N / 2) >> stage;
   endfunction

endpackage

// File: rtl/sdf_tw_addr_gen.sv
// Twiddle ROM address/enable decode for one SDF stage.
// Ports:
//   cnt_i     in  CNT_W  sample position within the frame (MSB = phase)
//   active_i  in  1      stage is emitting samples that may need twiddles (RUN or FLUSH)
//   tw_en_o   out 1      combinational: sample leaving the delay line needs the multiply
//   tw_addr_o out TW_AW  combinational: twiddle index k<<STAGE, 0 when tw_en_o is low
module sdf_tw_addr_gen
   import fft_pkg::*;
#(
   parameter int unsigned HALF  = 32,
   parameter int unsigned STAGE = 0,
   parameter int unsigned TW_AW = fft_pkg::TW_AW,
   parameter int unsigned CNT_W = $clog2(2 * HALF)
) (
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             active_i,
   output logic             tw_en_o,
   output logic [TW_AW-1:0] tw_addr_o
);

   logic [CNT_W-1:0] k;
   logic [TW_AW-1:0] k_ext;

   // Differences only leave the delay line during phase A (and the flush, which keeps phase A)
   always_comb begin
      k         = cnt_i & CNT_W'(HALF - 1);
      k_ext     = TW_AW'(k);
      tw_en_o   = active_i & ~cnt_i[CNT_W-1];
      tw_addr_o = tw_en_o ? (k_ext << STAGE) : '0;
   end

endmodule

// File: rtl/sdf_stage_ctrl.sv
// Sequencer for one radix-2 single-delay-feedback stage of the 64-point FFT.
// Tracks sample position, drives the butterfly/bypass select, twiddle ROM
// address/enable and output valid/sop strobes, and flags stream violations
// (the delay line shifts every clock, so gaps inside a frame are fatal to it).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_sop     input sample strobe and first-of-frame marker
//   bf_sel               combinational: 1 butterfly, 0 bypass
//   tw_en, tw_addr       combinational: twiddle multiply enable and ROM index
//   out_valid, out_sop   registered output strobes (one cycle behind the input)
//   err                  registered one-cycle violation pulse
//   busy                 state != IDLE
//   frame_cnt, err_cnt   only when SDF_STATS_EN is defined: out_sop count, saturating err count
// Optional feature macro: SDF_STATS_EN
module sdf_stage_ctrl
   import fft_pkg::*;
#(
   parameter int unsigned STAGE = 0,
   parameter int unsigned HALF  = half_of(STAGE),
   parameter int unsigned TW_AW = fft_pkg::TW_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_sop,
   output logic             bf_sel,
   output logic             tw_en,
   output logic [TW_AW-1:0] tw_addr,
   output logic             out_valid,
   output logic             out_sop,
   output logic             err,
   output logic             busy
`ifdef SDF_STATS_EN
   ,
   output logic [15:0]      frame_cnt,
   output logic [7:0]       err_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(2 * HALF);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF);
   localparam logic [CNT_W-1:0] CNT_HEND = CNT_W'(HALF - 1);
   // A one-deep stage has no fill and no flush beyond the wrap cycle itself
   localparam sdf_state_e START_ST = (HALF == 1) ? RUN : FILL;
   localparam sdf_state_e DRAIN_ST = (HALF == 1) ? IDLE : FLUSH;

   sdf_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             out_valid_q, out_valid_d;
   logic             out_sop_q, out_sop_d;
   logic             err_q, err_d;

   // Next state, counter and registered strobes
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid && in_sop) begin
               state_d = START_ST;
               cnt_d   = CNT_ONE;
            end
         end
         FILL: begin
            if (!in_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (in_sop) begin
               cnt_d   = CNT_ONE;
               err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_q == CNT_HEND) state_d = RUN;
            end
         end
         RUN: begin
            if (cnt_q == '0) begin
               // Frame boundary: the delay head holds difference 0 whichever way we go
               out_valid_d = 1'b1;
               if (in_valid && in_sop) begin
                  cnt_d = CNT_ONE;
               end else begin
                  // A sample without sop here cannot start a frame; drain instead
                  state_d = DRAIN_ST;
                  cnt_d   = (HALF == 1) ? '0 : CNT_ONE;
                  err_d   = in_valid;
               end
            end else if (!in_valid) begin
               state_d = IDLE;
               cnt_d   = '0;
               err_d   = 1'b1;
            end else if (in_sop) begin
               state_d = START_ST;
               cnt_d   = CNT_ONE;
               err_d   = 1'b1;
            end else begin
               out_valid_d = 1'b1;
               out_sop_d   = (cnt_q == CNT_HALF);
               cnt_d       = cnt_q + CNT_ONE;
            end
         end
         FLUSH: begin
            // cnt keeps counting phase-A positions so the twiddle index stays right
            out_valid_d = 1'b1;
            err_d       = in_valid;
            if (cnt_q == CNT_HEND) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and strobe registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         err_q       <= err_d;
      end
   end

   sdf_tw_addr_gen #(
      .HALF  (HALF),
      .STAGE (STAGE),
      .TW_AW (TW_AW),
      .CNT_W (CNT_W)
   ) u_tw (
      .cnt_i     (cnt_q),
      .active_i  ((state_q == RUN) || (state_q == FLUSH)),
      .tw_en_o   (tw_en),
      .tw_addr_o (tw_addr)
   );

   assign bf_sel    = (state_q == RUN) && cnt_q[CNT_W-1];
   assign busy      = (state_q != IDLE);
   assign out_valid = out_valid_q;
   assign out_sop   = out_sop_q;
   assign err       = err_q;

`ifdef SDF_STATS_EN
   logic [15:0] frame_cnt_q;
   logic [7:0]  err_cnt_q;

   // Frame and saturating error counters
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else begin
         frame_cnt_q <= frame_cnt_q + 16'(out_sop_q);
         if (err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// Bench for sdf_stage_ctrl: two instances (32-deep stage 0, 8-deep stage 2)
// share one input stream and are compared every cycle against a frame-level model.
module tb_sdf_stage_ctrl;

   logic clk = 1'b0;
   logic rst, in_valid, in_sop;
   always #5 clk = ~clk;

   logic       a_bf, a_twen, a_ov, a_osop, a_err, a_busy;
   logic [4:0] a_addr;
   logic       b_bf, b_twen, b_ov, b_osop, b_err, b_busy;
   logic [4:0] b_addr;
`ifdef SDF_STATS_EN
   logic [15:0] a_fc, b_fc;
   logic [7:0]  a_ec, b_ec;
`endif

   sdf_stage_ctrl #(.STAGE(0), .HALF(32), .TW_AW(5)) dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
      .bf_sel(a_bf), .tw_en(a_twen), .tw_addr(a_addr),
      .out_valid(a_ov), .out_sop(a_osop), .err(a_err), .busy(a_busy)
`ifdef SDF_STATS_EN
      , .frame_cnt(a_fc), .err_cnt(a_ec)
`endif
   );

   sdf_stage_ctrl #(.STAGE(2), .HALF(8), .TW_AW(5)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
      .bf_sel(b_bf), .tw_en(b_twen), .tw_addr(b_addr),
      .out_valid(b_ov), .out_sop(b_osop), .err(b_err), .busy(b_busy)
`ifdef SDF_STATS_EN
      , .frame_cnt(b_fc), .err_cnt(b_ec)
`endif
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int          cyc      = 0;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
      end
   endtask

   // Frame-level reference: mode 0 no frame, 1 streaming (pos = next sample index,
   // prev = an earlier frame's differences are still in the delay), 2 draining (d = diff index)
   typedef struct {
      int mode; int pos; bit prev; int d;
      bit ov; bit osop; bit err; int fc; int ec;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t step(input mdl_t m, input int h, input bit r, input bit v, input bit s);
      mdl_t n = m;
      if (r) begin
         n.mode = 0; n.pos = 0; n.prev = 0; n.d = 0;
         n.ov = 0; n.osop = 0; n.err = 0; n.fc = 0; n.ec = 0;
         return n;
      end
      n.fc = (m.fc + int'(m.osop)) % 65536;
      n.ec = (m.err && m.ec < 255) ? m.ec + 1 : m.ec;
      n.ov = 0; n.osop = 0; n.err = 0;
      case (m.mode)
         0: if (v && s) begin n.mode = 1; n.pos = 1; n.prev = 0; end
         1: begin
            if (m.pos == 0) begin
               n.ov = 1;
               if (v && s) n.pos = 1;
               else begin
                  n.err = v;
                  if (h == 1) n.mode = 0; else begin n.mode = 2; n.d = 1; end
               end
            end else if (!v) begin
               n.mode = 0; n.err = 1;
            end else if (s) begin
               n.err = 1; n.pos = 1; n.prev = 0;
            end else begin
               n.ov   = m.prev || (m.pos >= h);
               n.osop = (m.pos == h);
               n.pos  = m.pos + 1;
               if (n.pos == 2 * h) begin n.pos = 0; n.prev = 1; end
            end
         end
         default: begin
            n.ov = 1; n.err = v;
            if (m.d + 1 == h) n.mode = 0; else n.d = m.d + 1;
         end
      endcase
      return n;
   endfunction

   task automatic chk_dut(input string p, input mdl_t m, input int h, input int s,
                          input logic bf, input logic twen, input logic [4:0] addr,
                          input logic ov, input logic osop, input logic er, input logic bsy);
      bit e_bf, e_twen;
      int e_addr;
      e_bf   = (m.mode == 1) && (m.pos >= h);
      e_twen = ((m.mode == 1) && m.prev && (m.pos < h)) || (m.mode == 2);
      e_addr = !e_twen ? 0 : ((m.mode == 2 ? m.d : m.pos) * (1 << s)) % 32;
      chk({p, ".bf_sel"},    32'(bf),   32'(e_bf));
      chk({p, ".tw_en"},     32'(twen), 32'(e_twen));
      chk({p, ".tw_addr"},   32'(addr), 32'(e_addr));
      chk({p, ".out_valid"}, 32'(ov),   32'(m.ov));
      chk({p, ".out_sop"},   32'(osop), 32'(m.osop));
      chk({p, ".err"},       32'(er),   32'(m.err));
      chk({p, ".busy"},      32'(bsy),  32'(m.mode != 0));
   endtask

   // Per-test trackers (dut_a unless noted)
   int ov_n, ov_first, ov_last, sop_first, err_n, err_cyc, b_twen_n, b_tw_sum;

   task automatic trk_clear();
      ov_n = 0; ov_first = -1; ov_last = -1; sop_first = -1;
      err_n = 0; err_cyc = -1; b_twen_n = 0; b_tw_sum = 0;
   endtask

   task automatic tick(input bit r, input bit v, input bit s);
      rst = r; in_valid = v; in_sop = s;
      @(posedge clk);
      #1;
      cyc++;
      ma = step(ma, 32, r, v, s);
      mb = step(mb, 8, r, v, s);
      chk_dut("a", ma, 32, 0, a_bf, a_twen, a_addr, a_ov, a_osop, a_err, a_busy);
      chk_dut("b", mb, 8, 2, b_bf, b_twen, b_addr, b_ov, b_osop, b_err, b_busy);
`ifdef SDF_STATS_EN
      chk("a.frame_cnt", 32'(a_fc), 32'(ma.fc));
      chk("a.err_cnt",   32'(a_ec), 32'(ma.ec));
      chk("b.frame_cnt", 32'(b_fc), 32'(mb.fc));
      chk("b.err_cnt",   32'(b_ec), 32'(mb.ec));
`endif
      if (a_ov) begin
         if (ov_first < 0) ov_first = cyc;
         ov_last = cyc;
         ov_n++;
      end
      if (a_osop && sop_first < 0) sop_first = cyc;
      if (a_err) begin err_n++; err_cyc = cyc; end
      if (b_twen) begin b_twen_n++; b_tw_sum += int'(b_addr); end
   endtask

   task automatic frames(input int len, input int nfr);
      for (int f = 0; f < nfr; f++)
         for (int i = 0; i < len; i++) tick(1'b0, 1'b1, i == 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0);
   endtask

   int c0;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
      ma = step(ma, 32, 1'b1, 1'b0, 1'b0);
      mb = step(mb, 8, 1'b1, 1'b0, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 1'b0);
      idle(2);

      // One 64-sample frame then idle
      trk_clear(); c0 = cyc;
      frames(64, 1); idle(40);
      chk("t1.first_ov", 32'(ov_first - c0), 32'd33);
      chk("t1.last_ov",  32'(ov_last - c0),  32'd96);
      chk("t1.ov_count", 32'(ov_n),          32'd64);
      chk("t1.sop_at",   32'(sop_first - c0), 32'd33);

      // Two back-to-back frames: 128 contiguous outputs
      trk_clear();
      frames(64, 2); idle(40);
      chk("t2.ov_count", 32'(ov_n), 32'd128);
      chk("t2.ov_span",  32'(ov_last - ov_first + 1), 32'd128);

      // 8-deep stage, two 16-sample frames: 8 phase-A plus 8 drain twiddles 0,4,..,28 each
      trk_clear();
      frames(16, 2); idle(20);
      chk("t3.b_twen_count", 32'(b_twen_n), 32'd16);
      chk("t3.b_tw_sum",     32'(b_tw_sum), 32'd224);

      // in_valid dropped at cnt=40
      trk_clear();
      for (int i = 0; i < 40; i++) tick(1'b0, 1'b1, i == 0);
      idle(50);
      chk("t4.err_count", 32'(err_n), 32'd1);
      chk("t4.no_ov_after", 32'(ov_last < err_cyc), 32'd1);

      // sop reasserted at cnt=10 in FILL
      trk_clear();
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, i == 0);
      c0 = cyc;
      frames(64, 1); idle(40);
      chk("t5.err_count", 32'(err_n), 32'd1);
      chk("t5.first_ov",  32'(ov_first - c0), 32'd33);

      // Reset mid-RUN
      for (int i = 0; i < 50; i++) tick(1'b0, 1'b1, i == 0);
      tick(1'b1, 1'b1, 1'b0);
      chk("t6.busy", 32'(a_busy), 32'd0);
      chk("t6.ov",   32'(a_ov),   32'd0);
      idle(5);

      // Randomized streams with occasional violations, noise and resets
      for (int ep = 0; ep < 60; ep++) begin
         int len, nfr, gap;
         len = ($urandom_range(0, 1) != 0) ? 64 : 16;
         nfr = $urandom_range(1, 3);
         for (int f = 0; f < nfr; f++)
            for (int i = 0; i < len; i++) begin
               bit v, s;
               v = ($urandom_range(0, 199) != 0);
               s = (i == 0) || ($urandom_range(0, 199) == 0);
               tick($urandom_range(0, 299) == 0, v, s);
            end
         gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 40);
         for (int g = 0; g < gap; g++)
            tick($urandom_range(0, 299) == 0, $urandom_range(0, 15) == 0, 1'b0);
      end
      idle(40);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
